// File: rtl/cordic_share_arbiter_if.sv
// Requester-side and evaluator-side signals of cordic_share_arbiter. The arbiter
// uses the slave view; requesters and the evaluator model use the master view.
interface cordic_share_arbiter_if;
  // Handshake: rX_start is a level held by the requester until its one-cycle
  // rX_done (rX_result/rX_err are only meaningful while rX_done is high);
  // eval_start is a one-cycle pulse answered by a one-cycle eval_done/eval_result.
  logic        r0_start;
  logic        r1_start;
  logic [1:0]  r0_n;
  logic [1:0]  r1_n;
  logic [31:0] r0_dataa;
  logic [31:0] r0_datab;
  logic [31:0] r1_dataa;
  logic [31:0] r1_datab;
  logic        r0_done;
  logic        r1_done;
  logic [31:0] r0_result;
  logic [31:0] r1_result;
  logic        r0_err;
  logic        r1_err;
  logic        busy;
  logic        eval_clk_en;
  logic        eval_start;
  logic [1:0]  eval_n;
  logic [31:0] eval_x_one;
  logic [31:0] eval_x_two;
  logic        eval_done;
  logic [31:0] eval_result;

  modport slave (
    input  r0_start, r1_start, r0_n, r1_n, r0_dataa, r0_datab, r1_dataa, r1_datab,
           eval_done, eval_result,
    output r0_done, r1_done, r0_result, r1_result, r0_err, r1_err, busy,
           eval_clk_en, eval_start, eval_n, eval_x_one, eval_x_two
  );

  modport master (
    output r0_start, r1_start, r0_n, r1_n, r0_dataa, r0_datab, r1_dataa, r1_datab,
           eval_done, eval_result,
    input  r0_done, r1_done, r0_result, r1_result, r0_err, r1_err, busy,
           eval_clk_en, eval_start, eval_n, eval_x_one, eval_x_two
  );
endinterface

// File: rtl/cordic_share_arbiter.sv
// Round-robin arbiter sharing one function_evaluation unit between two requesters.
// Optional evaluator timeout is enabled with macro CORDIC_ARB_TIMEOUT_EN.
module cordic_share_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  cordic_share_arbiter_if.slave   bus,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [1:0]  n_q, n_d;
  logic [31:0] x1_q, x1_d;
  logic [31:0] x2_q, x2_d;
  logic [31:0] res_q, res_d;
  logic        grant;

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  // With both requesters pending, the one not served last wins.
  assign grant = (bus.r0_start && bus.r1_start) ? ~last_q : bus.r1_start;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      n_q     <= 2'd0;
      x1_q    <= 32'd0;
      x2_q    <= 32'd0;
      res_q   <= 32'd0;
`ifdef CORDIC_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      n_q     <= n_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      res_q   <= res_d;
`ifdef CORDIC_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    n_d     = n_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    res_d   = res_q;
`ifdef CORDIC_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.r0_start || bus.r1_start) begin
          owner_d = grant;
          n_d     = grant ? bus.r1_n     : bus.r0_n;
          x1_d    = grant ? bus.r1_dataa : bus.r0_dataa;
          x2_d    = grant ? bus.r1_datab : bus.r0_datab;
          state_d = ISSUE;
`ifdef CORDIC_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef CORDIC_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (bus.eval_done) begin
          res_d   = bus.eval_result;
          state_d = RESP;
        end
`ifdef CORDIC_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          res_d   = QNAN;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
`endif
      end
      RESP: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_dbg       = state_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.eval_start  = (state_q == ISSUE);
  assign bus.eval_clk_en = (state_q == ISSUE) || (state_q == WAIT);
  assign bus.eval_n      = n_q;
  assign bus.eval_x_one  = x1_q;
  assign bus.eval_x_two  = x2_q;

  // Result and error lines are gated by done so the non-owner always reads 0.
  assign bus.r0_done   = (state_q == RESP) && !owner_q;
  assign bus.r1_done   = (state_q == RESP) &&  owner_q;
  assign bus.r0_result = bus.r0_done ? res_q : 32'd0;
  assign bus.r1_result = bus.r1_done ? res_q : 32'd0;
`ifdef CORDIC_ARB_TIMEOUT_EN
  assign bus.r0_err    = bus.r0_done && err_q;
  assign bus.r1_err    = bus.r1_done && err_q;
`else
  assign bus.r0_err    = 1'b0;
  assign bus.r1_err    = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_share_arbiter.sv
// Self-checking bench for cordic_share_arbiter: evaluator model, result scoreboard,
// one task per scenario, protocol monitor and a single summary line.
module tb_cordic_share_arbiter;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  cordic_share_arbiter_if bus ();

  cordic_share_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int checks   = 0;
  int failures = 0;
  int viol     = 0;

  logic [31:0] exp_q[$];
  int          who_q[$];

  int          ev_delay     = 1;
  bit          ev_fixed     = 0;
  logic [31:0] ev_fixed_val = 32'd0;
  bit          ev_mute      = 0;
  bit          ev_abort     = 0;
  int          start_cnt    = 0;

  function automatic logic [31:0] model_fn(input logic [1:0] n, input logic [31:0] a,
                                           input logic [31:0] b);
    return a ^ {b[30:0], b[31]} ^ {30'd0, n};
  endfunction

  // Evaluator model: answers each eval_start after ev_delay cycles.
  initial begin
    bus.eval_done   = 1'b0;
    bus.eval_result = 32'd0;
    forever begin
      @(negedge clk);
      if (bus.eval_start === 1'b1) begin
        logic [31:0] r;
        bit          ab;
        start_cnt++;
        r  = ev_fixed ? ev_fixed_val : model_fn(bus.eval_n, bus.eval_x_one, bus.eval_x_two);
        ab = 0;
        for (int i = 0; i < ev_delay; i++) begin
          @(negedge clk);
          if (ev_abort) begin
            ab = 1;
            break;
          end
        end
        if (ev_abort) ab = 1;
        if (!ab && !ev_mute) begin
          bus.eval_done   = 1'b1;
          bus.eval_result = r;
          @(negedge clk);
          bus.eval_done   = 1'b0;
          bus.eval_result = 32'd0;
        end
        ev_abort = 0;
      end
    end
  end

  // Protocol monitor; the total is compared against zero at the end.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus.r0_done && bus.r1_done) viol++;
      if (!bus.r0_done && (bus.r0_result != 32'd0 || bus.r0_err)) viol++;
      if (!bus.r1_done && (bus.r1_result != 32'd0 || bus.r1_err)) viol++;
      if (bus.eval_start && state_dbg != 2'd1) viol++;
      if (bus.eval_clk_en && (state_dbg == 2'd0 || state_dbg == 2'd3)) viol++;
      if (state_dbg == 2'd2 && (!bus.eval_clk_en || bus.eval_start)) viol++;
`ifndef CORDIC_ARB_TIMEOUT_EN
      if (bus.r0_err || bus.r1_err) viol++;
`endif
    end
  end

  task automatic drive_req(input int id, input logic [1:0] n, input logic [31:0] a,
                           input logic [31:0] b);
    if (id == 0) begin
      bus.r0_start = 1'b1; bus.r0_n = n; bus.r0_dataa = a; bus.r0_datab = b;
    end else begin
      bus.r1_start = 1'b1; bus.r1_n = n; bus.r1_dataa = a; bus.r1_datab = b;
    end
  endtask

  task automatic drop_req(input int id);
    if (id == 0) bus.r0_start = 1'b0;
    else         bus.r1_start = 1'b0;
  endtask

  // Waits (bounded) for any done pulse and reports what was observed.
  task automatic wait_done(input int budget, output int cycles, output int who,
                           output logic [31:0] res, output logic err, output bit got);
    cycles = 0; who = -1; res = 32'd0; err = 1'b0; got = 0;
    while (!got && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (bus.r0_done || bus.r1_done) begin
        got = 1;
        who = bus.r1_done ? 1 : 0;
        res = bus.r1_done ? bus.r1_result : bus.r0_result;
        err = bus.r1_done ? bus.r1_err    : bus.r0_err;
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.r0_start = 1'b1; bus.r1_start = 1'b0;
    bus.r0_n = 2'd1; bus.r1_n = 2'd0;
    bus.r0_dataa = 32'hAAAA_5555; bus.r0_datab = 32'h1234_0000;
    bus.r1_dataa = 32'd0; bus.r1_datab = 32'd0;
    repeat (3) @(negedge clk);
    checks++; if (state_dbg !== 2'd0) begin failures++;
      $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    checks++; if (bus.busy !== 1'b0) begin failures++;
      $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    checks++; if ({bus.eval_clk_en, bus.eval_start} !== 2'b00) begin failures++;
      $display("FAIL reset_eval_ctl got=%0b%0b exp=00", bus.eval_clk_en, bus.eval_start); end
    checks++; if ({bus.eval_n, bus.eval_x_one, bus.eval_x_two} !== 66'd0) begin failures++;
      $display("FAIL reset_operands got=%0h/%0h/%0h exp=0", bus.eval_n, bus.eval_x_one, bus.eval_x_two); end
    checks++; if ({bus.r0_done, bus.r1_done, bus.r0_err, bus.r1_err} !== 4'd0) begin failures++;
      $display("FAIL reset_done_err got=%0b%0b%0b%0b exp=0000", bus.r0_done, bus.r1_done, bus.r0_err, bus.r1_err); end
    checks++; if ({bus.r0_result, bus.r1_result} !== 64'd0) begin failures++;
      $display("FAIL reset_results got=%0h/%0h exp=0", bus.r0_result, bus.r1_result); end
    bus.r0_start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int cyc, who, s0; logic [31:0] res, e; logic err; bit got;
    ev_fixed = 1; ev_fixed_val = 32'h1234_5678; ev_delay = 2;
    s0 = start_cnt;
    drive_req(0, 2'd1, 32'h40A0_0000, 32'h4120_0000);
    exp_q.push_back(32'h1234_5678); who_q.push_back(0);
    @(negedge clk);
    checks++; if ({bus.eval_start, bus.eval_clk_en} !== 2'b11) begin failures++;
      $display("FAIL single_issue got=%0b%0b exp=11", bus.eval_start, bus.eval_clk_en); end
    checks++; if ({bus.eval_n, bus.eval_x_one, bus.eval_x_two} !== {2'd1, 32'h40A0_0000, 32'h4120_0000}) begin
      failures++;
      $display("FAIL single_operands got=%0h/%0h/%0h exp=1/40a00000/41200000", bus.eval_n, bus.eval_x_one, bus.eval_x_two); end
    wait_done(20, cyc, who, res, err, got);
    e = exp_q.pop_front();
    checks++; if (got !== 1'b1 || who !== who_q.pop_front()) begin failures++;
      $display("FAIL single_owner got=%0d(seen %0b) exp=0", who, got); end
    checks++; if (res !== e) begin failures++;
      $display("FAIL single_result got=%0h exp=%0h", res, e); end
    checks++; if (cyc !== 3) begin failures++;
      $display("FAIL single_latency got=%0d exp=3", cyc); end
    checks++; if (start_cnt - s0 !== 1) begin failures++;
      $display("FAIL single_start_pulses got=%0d exp=1", start_cnt - s0); end
    drop_req(0);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.r0_done !== 1'b0) begin failures++;
      $display("FAIL single_back_idle got=busy%0b done%0b exp=00", bus.busy, bus.r0_done); end
    ev_fixed = 0;
  endtask

  task automatic test_min_latency_n3();
    int cyc, who; logic [31:0] res, e, a, b; logic err; bit got;
    ev_delay = 1;
    a = $urandom; b = $urandom;
    drive_req(1, 2'd3, a, b);
    exp_q.push_back(model_fn(2'd3, a, b)); who_q.push_back(1);
    @(negedge clk);
    checks++; if (bus.eval_n !== 2'd3) begin failures++;
      $display("FAIL n3_forward got=%0d exp=3", bus.eval_n); end
    wait_done(20, cyc, who, res, err, got);
    e = exp_q.pop_front();
    checks++; if (got !== 1'b1 || who !== who_q.pop_front()) begin failures++;
      $display("FAIL minlat_owner got=%0d exp=1", who); end
    checks++; if (res !== e || cyc !== 2) begin failures++;
      $display("FAIL minlat_result got=%0h@%0d exp=%0h@2", res, cyc, e); end
    drop_req(1);
    @(negedge clk);
  endtask

  task automatic test_contention();
    int cyc, who, s0; logic [31:0] res, e; logic err; bit got;
    logic [31:0] a0, b0, a1, b1;
    apply_reset();
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    s0 = start_cnt;
    ev_delay = $urandom_range(1, 4);
    drive_req(0, 2'd0, a0, b0);
    drive_req(1, 2'd2, a1, b1);
    exp_q.push_back(model_fn(2'd0, a0, b0)); who_q.push_back(0);
    exp_q.push_back(model_fn(2'd2, a1, b1)); who_q.push_back(1);
    for (int k = 0; k < 2; k++) begin
      int ew;
      wait_done(30, cyc, who, res, err, got);
      e = exp_q.pop_front(); ew = who_q.pop_front();
      checks++; if (got !== 1'b1 || who !== ew || res !== e) begin failures++;
        $display("FAIL contention_%0d got=r%0d:%0h exp=r%0d:%0h", k, who, res, ew, e); end
      drop_req(ew);
    end
    checks++; if (start_cnt - s0 !== 2) begin failures++;
      $display("FAIL contention_starts got=%0d exp=2", start_cnt - s0); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int cyc, who; logic [31:0] res, e; logic err; bit got;
    logic [31:0] a0, b0, a1, b1;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    ev_delay = $urandom_range(1, 3);
    drive_req(0, 2'd1, a0, b0);
    drive_req(1, 2'd1, a1, b1);
    for (int k = 0; k < 4; k++) begin
      who_q.push_back(k % 2);
      exp_q.push_back((k % 2) ? model_fn(2'd1, a1, b1) : model_fn(2'd1, a0, b0));
    end
    for (int k = 0; k < 4; k++) begin
      int ew;
      wait_done(30, cyc, who, res, err, got);
      e = exp_q.pop_front(); ew = who_q.pop_front();
      checks++; if (got !== 1'b1 || who !== ew || res !== e) begin failures++;
        $display("FAIL rr_grant_%0d got=r%0d:%0h exp=r%0d:%0h", k, who, res, ew, e); end
    end
    drop_req(0); drop_req(1);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc, who; logic [31:0] res, e, a, b; logic err; bit got;
    a = $urandom; b = $urandom;
    ev_delay = 10;
    drive_req(1, 2'd2, a, b);
    exp_q.push_back(model_fn(2'd2, a, b)); who_q.push_back(1);
    repeat (3) @(negedge clk);
    checks++; if (state_dbg !== 2'd2) begin failures++;
      $display("FAIL rstmid_in_wait got=%0d exp=2", state_dbg); end
    rst = 1'b0; ev_abort = 1;
    @(negedge clk);
    checks++; if ({bus.busy, bus.eval_clk_en, bus.eval_start, bus.r0_done, bus.r1_done} !== 5'd0
                  || {bus.eval_x_one, bus.eval_x_two, bus.r1_result} !== 96'd0) begin failures++;
      $display("FAIL rstmid_outputs got=busy%0b en%0b st%0b d%0b%0b x=%0h exp=all0", bus.busy,
               bus.eval_clk_en, bus.eval_start, bus.r0_done, bus.r1_done, bus.eval_x_one); end
    rst = 1'b1;
    wait_done(40, cyc, who, res, err, got);
    e = exp_q.pop_front();
    checks++; if (got !== 1'b1 || who !== who_q.pop_front() || res !== e || err !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_reserve got=r%0d:%0h err%0b exp=r1:%0h", who, res, err, e); end
    drop_req(1);
    @(negedge clk);
  endtask

  task automatic test_ignore();
    int cyc, who; logic [31:0] res, e, a, b, a1, b1; logic err; bit got;
    bus.eval_done = 1'b1; bus.eval_result = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.eval_done = 1'b0; bus.eval_result = 32'd0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || state_dbg !== 2'd0) begin failures++;
      $display("FAIL stray_done got=busy%0b state%0d exp=0/0", bus.busy, state_dbg); end
    a = $urandom; b = $urandom; a1 = $urandom; b1 = $urandom;
    ev_delay = 4;
    drive_req(0, 2'd0, a, b);
    exp_q.push_back(model_fn(2'd0, a, b)); who_q.push_back(0);
    @(negedge clk);
    @(negedge clk);
    bus.r0_dataa = ~a; bus.r0_n = 2'd3;
    drop_req(0);
    drive_req(1, 2'd1, a1, b1);
    @(negedge clk);
    checks++; if (bus.eval_x_one !== a || bus.eval_n !== 2'd0) begin failures++;
      $display("FAIL latched_stable got=%0h/%0d exp=%0h/0", bus.eval_x_one, bus.eval_n, a); end
    wait_done(30, cyc, who, res, err, got);
    e = exp_q.pop_front();
    checks++; if (got !== 1'b1 || who !== who_q.pop_front() || res !== e) begin failures++;
      $display("FAIL no_abort got=r%0d:%0h exp=r0:%0h", who, res, e); end
    exp_q.push_back(model_fn(2'd1, a1, b1)); who_q.push_back(1);
    wait_done(30, cyc, who, res, err, got);
    e = exp_q.pop_front();
    checks++; if (got !== 1'b1 || who !== who_q.pop_front() || res !== e) begin failures++;
      $display("FAIL late_request got=r%0d:%0h exp=r1:%0h", who, res, e); end
    drop_req(1);
    @(negedge clk);
  endtask

`ifdef CORDIC_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int cyc, who; logic [31:0] res, e; logic err; bit got;
    ev_mute = 1; ev_delay = 40;
    drive_req(0, 2'd1, $urandom, $urandom);
    exp_q.push_back(32'h7FC0_0000); who_q.push_back(0);
    @(negedge clk);
    wait_done(60, cyc, who, res, err, got);
    e = exp_q.pop_front();
    checks++; if (got !== 1'b1 || who !== who_q.pop_front() || res !== e || err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_resp got=r%0d:%0h err%0b exp=r0:%0h err1", who, res, err, e); end
    checks++; if (cyc !== TO + 1) begin failures++;
      $display("FAIL timeout_latency got=%0d exp=%0d", cyc, TO + 1); end
    drop_req(0);
    repeat (50) @(negedge clk);
    ev_mute = 0;
  endtask
`else
  task automatic test_long_wait();
    int cyc, who; logic [31:0] res, e, a, b; logic err; bit got;
    a = $urandom; b = $urandom;
    ev_delay = 200;
    drive_req(0, 2'd2, a, b);
    exp_q.push_back(model_fn(2'd2, a, b)); who_q.push_back(0);
    @(negedge clk);
    wait_done(300, cyc, who, res, err, got);
    e = exp_q.pop_front();
    checks++; if (got !== 1'b1 || who !== who_q.pop_front() || res !== e || err !== 1'b0) begin
      failures++;
      $display("FAIL long_wait got=r%0d:%0h err%0b exp=r0:%0h err0", who, res, err, e); end
    checks++; if (cyc !== 201) begin failures++;
      $display("FAIL long_wait_latency got=%0d exp=201", cyc); end
    drop_req(0);
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_min_latency_n3();
    test_contention();
    test_round_robin();
    test_reset_mid();
    test_ignore();
`ifdef CORDIC_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    repeat (3) @(negedge clk);
    checks++; if (viol !== 0) begin failures++;
      $display("FAIL protocol_monitor got=%0d exp=0", viol); end
    checks++; if (exp_q.size() !== 0) begin failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cordic_share_arbiter.md
CORDIC_SHARE_ARBITER -- requirements
Module: cordic_share_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64, maximum cycles waited for eval_done (used only with CORDIC_ARB_TIMEOUT_EN).
REQ-002 Port: clk  in  1  single clock; all logic rising-edge.
REQ-003 Port: rst  in  1  synchronous, active-low reset.
REQ-004 Port: r0_start, r1_start  in  1 each  request level; held high by the requester until its done pulse.
REQ-005 Port: r0_n, r1_n  in  2 each  op select (0=CLEAR, 1=GO, 2=READ, 3 reserved).
REQ-006 Port: r0_dataa, r0_datab, r1_dataa, r1_datab  in  32 each  IEEE-754 single operands.
REQ-007 Port: r0_done, r1_done  out  1 each  one-cycle completion pulse to the owner.
REQ-008 Port: r0_result, r1_result  out  32 each  result; valid only while the matching done is high, 0 otherwise.
REQ-009 Port: r0_err, r1_err  out  1 each  timeout flag; pulses with done.
REQ-010 Port: busy  out  1  high in every state except IDLE.
REQ-011 Port: eval_clk_en, eval_start  out  1 each  drive the shared function_evaluation clk_en and start.
REQ-012 Port: eval_n  out  2; eval_x_one, eval_x_two  out  32 each  latched op and operands to the evaluator.
REQ-013 Port: eval_done  in  1; eval_result  in  32  evaluator completion and result.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, advancing only on clk edges.
REQ-015 IDLE: with any rX_start high, SHALL grant one requester, latch its n/dataa/datab into eval_n/eval_x_one/eval_x_two, record the owner, and go to ISSUE.
REQ-016 Arbitration SHALL be round-robin: with both starts high, grant the requester not granted last; with one high, grant it.
REQ-017 ISSUE SHALL assert eval_start and eval_clk_en for exactly one cycle, then go to WAIT.
REQ-018 WAIT SHALL hold eval_clk_en high and eval_start low; on eval_done it SHALL latch eval_result and go to RESP.
REQ-019 RESP SHALL pulse the owner's rX_done for one cycle with rX_result equal to the latched result, update last-grant to the owner, and return to IDLE.
REQ-020 The non-owner's done/result/err SHALL stay 0 throughout.
REQ-021 eval_clk_en and eval_start SHALL be 0 in IDLE and RESP.
REQ-022 Minimum latency: start sampled in IDLE at cycle T gives ISSUE at T+1 and done at T+3 when eval_done arrives at T+2; each extra eval cycle adds one.
REQ-023 Requests arriving or changing outside IDLE SHALL be ignored until the next IDLE; latched operands SHALL NOT change during a transaction.
REQ-024 eval_done asserted outside WAIT SHALL be ignored.
REQ-025 A requester deasserting start mid-transaction SHALL NOT abort it; the done pulse is still issued.
REQ-026 n=3 SHALL be forwarded unchanged; the arbiter does not decode op semantics.

Reset
REQ-027 While rst=0 at a clk edge: state SHALL be IDLE; all outputs 0; latched operands and result 0; last-grant = requester 1, so requester 0 wins the first contention.
REQ-028 Reset mid-transaction SHALL drop the transaction without a done pulse; a requester still holding start is re-arbitrated after reset releases.

Configuration
REQ-029 Macro CORDIC_ARB_TIMEOUT_EN defined: WAIT SHALL count cycles from entry; if eval_done is absent after TIMEOUT_CYCLES cycles, go to RESP with result 32'h7FC00000 (qNaN) and pulse the owner's rX_err with rX_done.
REQ-030 Macro not defined: no counter; WAIT lasts until eval_done; r0_err and r1_err SHALL be constant 0.

Verification
REQ-031 r0_start=1, n=1, dataa=32'h40A00000, datab=32'h41200000; eval model returns 32'h12345678 two cycles after eval_start -> eval_x_one/eval_x_two match, one eval_start pulse, r0_done one cycle with r0_result=32'h12345678, r1_done=0.
REQ-032 r0 and r1 both start in the same cycle after reset -> r0 is served first, then r1; never two concurrent eval_start pulses.
REQ-033 Both starts held high continuously for 4 transactions -> grants alternate r0,r1,r0,r1.
REQ-034 rst=0 for one cycle during WAIT -> no done pulse, busy=0 and all outputs 0 next cycle; the held r1 request is then re-served to completion.
REQ-035 With CORDIC_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, eval_done never asserted -> owner done and err pulse after 8 WAIT cycles, result 32'h7FC00000.
REQ-036 Without the macro, eval_done delayed 200 cycles -> no err; done arrives one cycle after eval_done with the correct result.
